// File: rtl/instr_trace_buffer.sv
// Circular instruction trace buffer: captures retired-instruction records,
// with wrap/stop-on-full modes, an opcode trigger and an oldest-first drain port.
module instr_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int XLEN      = 32,
  parameter int POST_TRIG = 4,
  localparam int ENTRY_W  = 10 + 2*XLEN,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_valid,
  input  logic [XLEN-1:0]    instr,
  input  logic [4:0]         alu_opcode,
  input  logic [4:0]         rd_sel,
  input  logic [XLEN-1:0]    rd_data,
  input  logic               arm,
  input  logic               abort,
  input  logic               mode,
  input  logic               trig_en,
  input  logic [4:0]         trig_opcode,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic               rd_last,
  output logic [1:0]         state,
  output logic [AW:0]        count,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FULL_M1   = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  logic [ENTRY_W-1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [AW:0]   count_d;
  logic          overflow_d;
  logic [AW-1:0] post_left, post_left_d;
  logic          mode_q, mode_d;
  logic          trig_en_q, trig_en_d;
  logic [4:0]    trig_op_q, trig_op_d;
  logic          cap_we;
  logic          reach_full;
  logic [AW-1:0] rd_ptr;

  // Next-state and control update; abort beats arm beats capture/readout.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr;
    count_d     = count;
    overflow_d  = overflow;
    post_left_d = post_left;
    mode_d      = mode_q;
    trig_en_d   = trig_en_q;
    trig_op_d   = trig_op_q;
    cap_we      = 1'b0;
    reach_full  = (count == FULL_M1);
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            mode_d     = mode;
            trig_en_d  = trig_en;
            trig_op_d  = trig_opcode;
          end
        end
        ARMED, POST: begin
          if (cap_valid) begin
            cap_we   = 1'b1;
            wr_ptr_d = wr_ptr + 1'b1;
            if (count == FULL) overflow_d = 1'b1;
            else               count_d    = count + 1'b1;
            if (state_q == ARMED) begin
              if (trig_en_q && (alu_opcode == trig_op_q)) begin
                post_left_d = POST_INIT;
                state_d     = (POST_TRIG == 0) ? DONE : POST;
              end
              if (mode_q && reach_full) state_d = DONE;
            end else begin
              post_left_d = post_left - 1'b1;
              if ((post_left == AW'(1)) || (mode_q && reach_full)) state_d = DONE;
            end
          end
        end
        DONE: begin
          if (count == '0) begin
            state_d = IDLE;
          end else if (rd_ready) begin
            count_d = count - 1'b1;
            if (count == (AW+1)'(1)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      post_left <= '0;
      mode_q    <= 1'b0;
      trig_en_q <= 1'b0;
      trig_op_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr    <= wr_ptr_d;
      count     <= count_d;
      overflow  <= overflow_d;
      post_left <= post_left_d;
      mode_q    <= mode_d;
      trig_en_q <= trig_en_d;
      trig_op_q <= trig_op_d;
    end
  end

  // Storage carries no reset; only the pointers say what is valid.
  always_ff @(posedge clk) begin
    if (cap_we) mem[wr_ptr] <= {alu_opcode, rd_sel, instr, rd_data};
  end

  // Oldest record sits count entries behind the write pointer.
  assign rd_ptr   = wr_ptr - count[AW-1:0];
  assign rd_valid = (state_q == DONE) && (count != '0);
  assign rd_entry = rd_valid ? mem[rd_ptr] : '0;
  assign rd_last  = rd_valid && (count == (AW+1)'(1));
  assign state    = state_q;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed bench for instr_trace_buffer: vector table plus hand-written
// capture/drain sequences against bench-computed records.
module tb_instr_trace_buffer;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int EW    = 10 + 2*XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cap_valid = 1'b0, cap_valid0 = 1'b0;
  logic [XLEN-1:0] instr = '0;
  logic [4:0]      alu_opcode = '0;
  logic [4:0]      rd_sel = '0;
  logic [XLEN-1:0] rd_data = '0;
  logic            arm = 1'b0, arm0 = 1'b0;
  logic            abort = 1'b0, abort0 = 1'b0;
  logic            mode = 1'b0;
  logic            trig_en = 1'b0;
  logic [4:0]      trig_opcode = '0;
  logic            rd_ready = 1'b0, rd_ready0 = 1'b0;

  logic          rd_valid, rd_last, overflow;
  logic [EW-1:0] rd_entry;
  logic [1:0]    state;
  logic [4:0]    count;
  logic          rd_valid0, rd_last0, overflow0;
  logic [EW-1:0] rd_entry0;
  logic [1:0]    state0;
  logic [4:0]    count0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .POST_TRIG(4)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .instr(instr),
    .alu_opcode(alu_opcode), .rd_sel(rd_sel), .rd_data(rd_data),
    .arm(arm), .abort(abort), .mode(mode), .trig_en(trig_en),
    .trig_opcode(trig_opcode), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_entry(rd_entry), .rd_last(rd_last), .state(state), .count(count),
    .overflow(overflow)
  );

  instr_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .POST_TRIG(0)) dut0 (
    .clk(clk), .rst(rst), .cap_valid(cap_valid0), .instr(instr),
    .alu_opcode(alu_opcode), .rd_sel(rd_sel), .rd_data(rd_data),
    .arm(arm0), .abort(abort0), .mode(mode), .trig_en(trig_en),
    .trig_opcode(trig_opcode), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
    .rd_entry(rd_entry0), .rd_last(rd_last0), .state(state0), .count(count0),
    .overflow(overflow0)
  );

  typedef struct {
    logic       cap;
    logic       arm;
    logic       abort;
    logic       mode;
    logic       ten;
    logic [4:0] opc;
    logic [7:0] data;
    logic [1:0] st;
    logic [4:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [4:0] opc_of(input int d);
    if (d == 10) return 5'h0A;
    if (d == 18) return 5'h12;
    return 5'h01;
  endfunction

  function automatic logic [XLEN-1:0] instr_of(input int d);
    logic [XLEN-1:0] v;
    v = XLEN'(d);
    return 32'hA500_0000 | v;
  endfunction

  function automatic logic [EW-1:0] mk_entry(input logic [4:0] opc, input int d);
    logic [XLEN-1:0] v;
    v = XLEN'(d);
    return {opc, v[4:0], instr_of(d), v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic present(input logic [4:0] opc, input int d);
    logic [XLEN-1:0] v;
    v = XLEN'(d);
    alu_opcode = opc;
    rd_sel     = v[4:0];
    instr      = instr_of(d);
    rd_data    = v;
  endtask

  task automatic cap(input logic [4:0] opc, input int d);
    present(opc, d);
    cap_valid = 1'b1;
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic do_arm(input logic m, input logic te, input logic [4:0] top);
    mode = m; trig_en = te; trig_opcode = top;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain(input string name, input int n, input int first);
    for (int i = 0; i < n; i++) begin
      check({name, " rd_valid"}, 128'(rd_valid), 128'(1));
      check({name, " rd_entry"}, 128'(rd_entry), 128'(mk_entry(opc_of(first + i), first + i)));
      check({name, " rd_last"}, 128'(rd_last), 128'(i == n - 1));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    check({name, " idle after drain"}, 128'(state), 128'(2'b00));
    check({name, " rd_valid after drain"}, 128'(rd_valid), 128'(0));
  endtask

  initial begin
    int idx;

    // Reset state
    tick();
    check("reset state", 128'(state), 128'(0));
    check("reset count", 128'(count), 128'(0));
    check("reset overflow", 128'(overflow), 128'(0));
    check("reset rd_valid", 128'(rd_valid), 128'(0));
    check("reset rd_last", 128'(rd_last), 128'(0));
    check("reset rd_entry", 128'(rd_entry), 128'(0));
    #2 rst = 1'b1;
    tick();

    // Vector table: arm/abort priority, ignored captures, trigger into POST
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'h01, 8'd0, 2'd1, 5'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'h01, 8'd1, 2'd1, 5'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'h01, 8'd2, 2'd1, 5'd2, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h01, 8'd0, 2'd1, 5'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'h01, 8'd3, 2'd0, 5'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'h01, 8'd4, 2'd0, 5'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'h01, 8'd0, 2'd0, 5'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h01, 8'd0, 2'd1, 5'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h0A, 8'd5, 2'd2, 5'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h0A, 8'd6, 2'd2, 5'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h01, 8'd0, 2'd2, 5'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'h01, 8'd0, 2'd0, 5'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'h01, 8'd0, 2'd1, 5'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'h01, 8'd0, 2'd0, 5'd0, 1'b0};
    trig_opcode = 5'h0A;
    for (int i = 0; i < 14; i++) begin
      present(tbl[i].opc, int'(tbl[i].data));
      cap_valid = tbl[i].cap;
      arm       = tbl[i].arm;
      abort     = tbl[i].abort;
      mode      = tbl[i].mode;
      trig_en   = tbl[i].ten;
      tick();
      cap_valid = 1'b0; arm = 1'b0; abort = 1'b0;
      check($sformatf("vec%0d state", i), 128'(state), 128'(tbl[i].st));
      check($sformatf("vec%0d count", i), 128'(count), 128'(tbl[i].cnt));
      check($sformatf("vec%0d overflow", i), 128'(overflow), 128'(tbl[i].ovf));
    end

    // Wrap mode, no trigger, 20 records then abort
    do_arm(1'b0, 1'b0, 5'h00);
    for (int d = 1; d <= 20; d++) cap(opc_of(d), d);
    check("wrap state", 128'(state), 128'(2'b01));
    check("wrap count", 128'(count), 128'(16));
    check("wrap overflow", 128'(overflow), 128'(1));
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort state", 128'(state), 128'(0));
    check("abort count", 128'(count), 128'(0));
    check("abort keeps overflow", 128'(overflow), 128'(1));

    // Trigger at record 10, four post records
    do_arm(1'b0, 1'b1, 5'h0A);
    check("rearm clears overflow", 128'(overflow), 128'(0));
    for (int d = 1; d <= 20; d++) begin
      cap(opc_of(d), d);
      if (d == 10) check("trig enters POST", 128'(state), 128'(2'b10));
      if (d == 13) check("POST before last", 128'(state), 128'(2'b10));
      if (d == 14) check("DONE after 14", 128'(state), 128'(2'b11));
    end
    check("trig count", 128'(count), 128'(14));
    drain("trig drain", 14, 1);

    // Stop mode: 18 records, last two dropped
    do_arm(1'b1, 1'b0, 5'h00);
    for (int d = 1; d <= 18; d++) cap(opc_of(d), d);
    check("stop state", 128'(state), 128'(2'b11));
    check("stop count", 128'(count), 128'(16));
    check("stop overflow", 128'(overflow), 128'(0));
    drain("stop drain", 16, 1);

    // Backpressure: rd_ready toggles, entry must hold while stalled
    do_arm(1'b1, 1'b0, 5'h00);
    for (int d = 1; d <= 16; d++) cap(opc_of(d), d);
    idx = 0;
    for (int cyc = 0; cyc < 64 && idx < 16; cyc++) begin
      rd_ready = cyc[0];
      check("bp rd_valid", 128'(rd_valid), 128'(1));
      check("bp rd_entry", 128'(rd_entry), 128'(mk_entry(opc_of(idx + 1), idx + 1)));
      tick();
      if (rd_ready) idx++;
    end
    rd_ready = 1'b0;
    check("bp pops", 128'(idx), 128'(16));
    check("bp idle", 128'(state), 128'(0));

    // Reset mid-drain on a wrapped, triggered session
    do_arm(1'b0, 1'b1, 5'h12);
    for (int d = 1; d <= 22; d++) cap(opc_of(d), d);
    check("late trig DONE", 128'(state), 128'(2'b11));
    check("late trig overflow", 128'(overflow), 128'(1));
    check("late trig oldest", 128'(rd_entry), 128'(mk_entry(opc_of(7), 7)));
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    check("after 3 pops", 128'(rd_entry), 128'(mk_entry(opc_of(10), 10)));
    #2 rst = 1'b0;
    #1;
    check("async rst rd_valid", 128'(rd_valid), 128'(0));
    check("async rst count", 128'(count), 128'(0));
    check("async rst overflow", 128'(overflow), 128'(0));
    check("async rst rd_entry", 128'(rd_entry), 128'(0));
    check("async rst state", 128'(state), 128'(0));
    #2 rst = 1'b1;
    tick();
    cap(opc_of(1), 1);
    check("idle ignores cap state", 128'(state), 128'(0));
    check("idle ignores cap count", 128'(count), 128'(0));

    // POST_TRIG = 0 instance: trigger on first record
    mode = 1'b0; trig_en = 1'b1; trig_opcode = 5'h0A;
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    check("pt0 armed", 128'(state0), 128'(2'b01));
    present(5'h0A, 33);
    cap_valid0 = 1'b1; tick(); cap_valid0 = 1'b0;
    check("pt0 DONE", 128'(state0), 128'(2'b11));
    check("pt0 count", 128'(count0), 128'(1));
    check("pt0 rd_valid", 128'(rd_valid0), 128'(1));
    check("pt0 rd_last", 128'(rd_last0), 128'(1));
    check("pt0 rd_entry", 128'(rd_entry0), 128'(mk_entry(5'h0A, 33)));
    rd_ready0 = 1'b1; tick(); rd_ready0 = 1'b0;
    check("pt0 idle", 128'(state0), 128'(0));
    check("pt0 rd_valid after", 128'(rd_valid0), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
